riscv_v_mul_ctrl: RTL and testbench

RISCV_V_MUL_CTRL -- requirements
Module: riscv_v_mul_ctrl

---
 rtl/riscv_v_pkg.sv | 26 ++
 rtl/riscv_v_mul_res_fifo.sv | 83 ++++++++
 rtl/riscv_v_mul_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_riscv_v_mul_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_pkg
// Description : Shared types and widths for the vector multiply controller.
//               Holds the controller state encoding, the beat counter width,
//               and the multiplier operand/result widths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

    // Beat count field width; a command carries beats_m1 in this many bits.
    localparam int MUL_CTRL_BEATS_W = 3;

    // Multiplier operand format: 128 data + 16 sign-ext + 16 merge bits.
    localparam int MUL_OP_W    = 160;
    localparam int MUL_RES_W   = 128;
    localparam int MUL_OSIZE_W = 5;

    typedef enum logic [1:0] {
        MUL_CTRL_IDLE  = 2'd0,
        MUL_CTRL_ISSUE = 2'd1,
        MUL_CTRL_DRAIN = 2'd2
    } mul_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_v_mul_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_mul_res_fifo
// Description : Synchronous result FIFO for the multiply controller.
//               Write side has no ready: the upstream credit scheme
//               guarantees a write never arrives when the FIFO is full.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_wr_valid/data - push request and payload
//               o_rd_valid/data - head entry present / head payload
//               i_rd_ready      - consumer accepts head entry
//               o_count         - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_mul_res_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_valid,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic                       o_rd_valid,
    input  logic                       i_rd_ready,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign w_push     = i_wr_valid;
    assign w_pop      = o_rd_valid & i_rd_ready;
    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = r_mem[r_rptr];
    assign o_count    = r_count;

    function automatic logic [c_AW-1:0] ptr_next(input logic [c_AW-1:0] ptr);
        ptr_next = (ptr == c_AW'(DEPTH - 1)) ? '0 : ptr + c_AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        w_push |-> (r_count != c_CW'(DEPTH)));

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        w_pop |-> (r_count != '0));

endmodule
`default_nettype wire

// File: rtl/riscv_v_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_v_mul_ctrl
// Description : Multi-beat command controller for the vector multiplier.
//               Accepts a command (flags, output size, beat count), issues
//               one operand pair per beat to the external multiplier, pipes
//               each result through MUL_LAT register stages into a result
//               FIFO and hands results out in issue order with res_last on
//               the final beat.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               cmd_*                   - command handshake and fields
//               op_*                    - per-beat operand handshake
//               mul_*                   - combinational multiplier drive/result
//               res_*                   - result handshake, data, last flag
//               busy                    - command or results outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_v_mul_ctrl
    import riscv_v_pkg::*;
#(
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_is_high,
    input  logic                        cmd_is_signed,
    input  logic [MUL_OSIZE_W-1:0]      cmd_osize_vector,
    input  logic [MUL_CTRL_BEATS_W-1:0] cmd_beats_m1,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [MUL_OP_W-1:0]         op_srca,
    input  logic [MUL_OP_W-1:0]         op_srcb,
    output logic                        mul_is_mul,
    output logic                        mul_is_high,
    output logic                        mul_is_signed,
    output logic [MUL_OSIZE_W-1:0]      mul_osize_vector,
    output logic [MUL_OP_W-1:0]         mul_srca,
    output logic [MUL_OP_W-1:0]         mul_srcb,
    input  logic [MUL_RES_W-1:0]        mul_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [MUL_RES_W-1:0]        res_data,
    output logic                        res_last,
    output logic                        busy
);

    localparam logic [1:0] c_ST_IDLE  = MUL_CTRL_IDLE;
    localparam logic [1:0] c_ST_ISSUE = MUL_CTRL_ISSUE;
    localparam logic [1:0] c_ST_DRAIN = MUL_CTRL_DRAIN;

    localparam int c_CNT_W   = MUL_CTRL_BEATS_W + 1;
    localparam int c_FIFO_CW = $clog2(FIFO_DEPTH) + 1;
    localparam int c_CRED_W  = $clog2(FIFO_DEPTH + MUL_LAT + 1) + 1;
    localparam int c_ENTRY_W = MUL_RES_W + 1;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_beats;
    logic                   r_is_high;
    logic                   r_is_signed;
    logic [MUL_OSIZE_W-1:0] r_osize;

    logic [MUL_LAT-1:0]     r_stg_vld;
    logic [c_ENTRY_W-1:0]   r_stg_data [MUL_LAT];

    logic                   w_fire;
    logic                   w_last_beat;
    logic [c_CRED_W-1:0]    w_inflight;
    logic [c_CRED_W-1:0]    w_used;
    logic                   w_credit_ok;
    logic                   w_fifo_valid;
    logic [c_ENTRY_W-1:0]   w_fifo_data;
    logic [c_FIFO_CW-1:0]   w_fifo_count;
    logic                   w_pop_last;

    // Credit counts come from registers only, so a pop in this cycle
    // frees its slot for issue in the following cycle.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            w_inflight = w_inflight + {{(c_CRED_W-1){1'b0}}, r_stg_vld[i]};
        end
    end

    assign w_used      = w_inflight + c_CRED_W'(w_fifo_count);
    assign w_credit_ok = (w_used < c_CRED_W'(FIFO_DEPTH));

    assign cmd_ready   = (r_state == c_ST_IDLE);
    assign op_ready    = (r_state == c_ST_ISSUE) && w_credit_ok;
    assign w_fire      = op_valid & op_ready;
    assign w_last_beat = (r_beats == c_CNT_W'(1));

    assign mul_is_mul       = w_fire;
    assign mul_is_high      = r_is_high;
    assign mul_is_signed    = r_is_signed;
    assign mul_osize_vector = r_osize;
    assign mul_srca         = op_srca;
    assign mul_srcb         = op_srcb;

    assign res_valid  = w_fifo_valid;
    assign res_data   = w_fifo_data[c_ENTRY_W-1:1];
    assign res_last   = w_fifo_valid & w_fifo_data[0];
    assign w_pop_last = w_fifo_valid & res_ready & w_fifo_data[0];

    assign busy = (r_state != c_ST_IDLE) || (|r_stg_vld) || w_fifo_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_beats     <= '0;
            r_is_high   <= 1'b0;
            r_is_signed <= 1'b0;
            r_osize     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_is_high   <= cmd_is_high;
                        r_is_signed <= cmd_is_signed;
                        r_osize     <= cmd_osize_vector;
                        r_beats     <= {1'b0, cmd_beats_m1} + c_CNT_W'(1);
                        r_state     <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_fire) begin
                        r_beats <= r_beats - c_CNT_W'(1);
                        if (w_last_beat) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_pop_last) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Result stages shift every cycle; the credit rule keeps the FIFO from
    // overflowing, so no stall path is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_vld <= '0;
        end else begin
            r_stg_vld[0] <= w_fire;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_stg_vld[i] <= r_stg_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_stg_data[0] <= {mul_result, w_last_beat};
        for (int i = 1; i < MUL_LAT; i++) begin
            r_stg_data[i] <= r_stg_data[i-1];
        end
    end

    riscv_v_mul_res_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (r_stg_vld[MUL_LAT-1]),
        .i_wr_data  (r_stg_data[MUL_LAT-1]),
        .o_rd_valid (w_fifo_valid),
        .i_rd_ready (res_ready),
        .o_rd_data  (w_fifo_data),
        .o_count    (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_riscv_v_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_v_mul_ctrl
// Description : Self-checking bench for riscv_v_mul_ctrl: a table of
//               commands streamed with res_ready high, plus hand sequences
//               for latency, backpressure, push/pop at count 3, reset
//               mid-command and command blocking while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_v_mul_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_is_high, cmd_is_signed;
    logic [4:0]   cmd_osize_vector;
    logic [2:0]   cmd_beats_m1;
    logic         op_valid, op_ready;
    logic [159:0] op_srca, op_srcb;
    logic         mul_is_mul, mul_is_high, mul_is_signed;
    logic [4:0]   mul_osize_vector;
    logic [159:0] mul_srca, mul_srcb;
    logic [127:0] mul_result;
    logic         res_valid, res_ready, res_last, busy;
    logic [127:0] res_data;

    always #5 clk = ~clk;

    riscv_v_mul_ctrl #(.MUL_LAT(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_high(cmd_is_high), .cmd_is_signed(cmd_is_signed),
        .cmd_osize_vector(cmd_osize_vector), .cmd_beats_m1(cmd_beats_m1),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_srca(op_srca), .op_srcb(op_srcb),
        .mul_is_mul(mul_is_mul), .mul_is_high(mul_is_high),
        .mul_is_signed(mul_is_signed), .mul_osize_vector(mul_osize_vector),
        .mul_srca(mul_srca), .mul_srcb(mul_srcb),
        .mul_result(mul_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    typedef struct packed { logic [127:0] data; logic last; } res_t;
    res_t exp_q[$];

    // Expected multiplier drive fields for the command being issued.
    logic       g_hi, g_sg;
    logic [4:0] g_osz;

    typedef struct {
        logic         hi;
        logic         sg;
        logic [4:0]   osz;
        logic [2:0]   bm1;
        logic [127:0] base;
        int           exp_beats;
        logic         exp_hi;
        logic         exp_sg;
        logic [4:0]   exp_osz;
        int           exp_stalls;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard: every pop must match the oldest fired beat, and
    // a held result must not change while res_ready is low.
    logic         prev_hold = 1'b0;
    logic [127:0] prev_data;
    logic         prev_last;
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_data", res_data, prev_data);
                    check("hold_last", res_last, prev_last);
                end
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pop", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_last", res_last, e.last);
                        pops++;
                    end
                end
                prev_hold = res_valid && !res_ready;
                prev_data = res_data;
                prev_last = res_last;
            end
        end
    end

    task automatic issue_cmd(input logic hi, input logic sg, input logic [4:0] osz,
                             input logic [2:0] bm1);
        cmd_valid = 1'b1; cmd_is_high = hi; cmd_is_signed = sg;
        cmd_osize_vector = osz; cmd_beats_m1 = bm1;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    // Fire beats [start, stop) of a command with `total_b` beats; waits
    // (bounded) for op_ready on each and counts stall cycles.
    task automatic send_beats(input int start, input int stop, input int total_b,
                              input logic [127:0] base, output int stalls);
        logic [31:0] tag;
        int w;
        stalls = 0;
        for (int i = start; i < stop; i++) begin
            tag        = 32'hA000_0000 + 32'(i);
            op_valid   = 1'b1;
            op_srca    = {tag, base};
            op_srcb    = ~{tag, base};
            mul_result = base + 128'(i);
            for (w = 0; w < 100; w++) begin
                @(negedge clk);
                if (op_ready) break;
                stalls++;
                cyc();
            end
            if (w == 100) begin
                check("op_ready_timeout", 0, 1);
                op_valid = 1'b0;
                return;
            end
            check("mul_is_mul", mul_is_mul, 1);
            check("mul_srca", mul_srca, op_srca);
            check("mul_srcb", mul_srcb, op_srcb);
            check("mul_is_high", mul_is_high, g_hi);
            check("mul_is_signed", mul_is_signed, g_sg);
            check("mul_osize", mul_osize_vector, g_osz);
            exp_q.push_back('{data: base + 128'(i), last: (i == total_b - 1)});
            cyc();
        end
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (cmd_ready && !busy && exp_q.size() == 0) break;
            cyc();
        end
        if (w == 100) check("idle_timeout", 0, 1);
        else cyc();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int p0, st, fires;
        logic [127:0] base;

        vecs[0] = '{1'b0, 1'b0, 5'b00001, 3'd0, 128'h1111_0000, 1, 1'b0, 1'b0, 5'b00001, 0};
        vecs[1] = '{1'b1, 1'b1, 5'b00010, 3'd2, 128'h2222_0000, 3, 1'b1, 1'b1, 5'b00010, 0};
        vecs[2] = '{1'b0, 1'b1, 5'b00100, 3'd7, 128'h3333_0000, 8, 1'b0, 1'b1, 5'b00100, 0};
        vecs[3] = '{1'b1, 1'b0, 5'b10101, 3'd3, 128'h4444_0000, 4, 1'b1, 1'b0, 5'b10101, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_is_high = 1'b0; cmd_is_signed = 1'b0;
        cmd_osize_vector = '0; cmd_beats_m1 = '0; op_valid = 1'b0;
        op_srca = '0; op_srcb = '0; mul_result = '0; res_ready = 1'b1;
        g_hi = 1'b0; g_sg = 1'b0; g_osz = '0;
        cyc(); cyc();
        rst = 1'b0;
        op_valid = 1'b1;          // ignored while idle
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_op_ready", op_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_is_mul", mul_is_mul, 0);
        cyc();
        op_valid = 1'b0;

        // Single beat: result three cycles after the fire, idle after pop.
        g_hi = 1'b0; g_sg = 1'b0; g_osz = 5'b00001;
        issue_cmd(1'b0, 1'b0, 5'b00001, 3'd0);
        op_valid = 1'b1; op_srca = 160'h5; op_srcb = 160'h6; mul_result = 128'h1234;
        @(negedge clk);
        check("lat_op_ready", op_ready, 1);
        exp_q.push_back('{data: 128'h1234, last: 1'b1});
        cyc();
        op_valid = 1'b0;
        @(negedge clk); check("lat_t1_valid", res_valid, 0); check("lat_t1_op_ready", op_ready, 0); cyc();
        @(negedge clk); check("lat_t2_valid", res_valid, 0); check("lat_t2_busy", busy, 1); cyc();
        @(negedge clk);
        check("lat_t3_valid", res_valid, 1);
        check("lat_t3_data", res_data, 128'h1234);
        check("lat_t3_last", res_last, 1);
        cyc();
        @(negedge clk); check("lat_t4_valid", res_valid, 0); cyc();
        @(negedge clk); check("lat_t5_busy", busy, 0); check("lat_t5_cmd_ready", cmd_ready, 1); cyc();

        // Table of commands streamed back to back with res_ready high.
        for (int v = 0; v < 4; v++) begin
            p0 = pops;
            g_hi = vecs[v].exp_hi; g_sg = vecs[v].exp_sg; g_osz = vecs[v].exp_osz;
            issue_cmd(vecs[v].hi, vecs[v].sg, vecs[v].osz, vecs[v].bm1);
            send_beats(0, vecs[v].exp_beats, vecs[v].exp_beats, vecs[v].base, st);
            check("vec_stalls", st, vecs[v].exp_stalls);
            wait_idle();
            check("vec_pops", pops - p0, vecs[v].exp_beats);
            check("vec_cmd_ready", cmd_ready, 1);
        end

        // Backpressure: credit stops issue after 4 fires.
        p0 = pops; base = 128'h5555_0000;
        g_hi = 1'b0; g_sg = 1'b0; g_osz = 5'b01000;
        res_ready = 1'b0;
        issue_cmd(1'b0, 1'b0, 5'b01000, 3'd7);
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            op_valid = 1'b1; op_srca = {32'hA000_0000 + 32'(fires), base};
            op_srcb = ~op_srca; mul_result = base + 128'(fires);
            @(negedge clk);
            if (op_ready) begin
                exp_q.push_back('{data: base + 128'(fires), last: 1'b0});
                fires++;
            end
            cyc();
        end
        op_valid = 1'b0;
        check("bp_fires", fires, 4);
        @(negedge clk);
        check("bp_op_ready", op_ready, 0);
        check("bp_res_valid", res_valid, 1);
        cyc();
        res_ready = 1'b1;
        send_beats(fires, 8, 8, base, st);
        wait_idle();
        check("bp_pops", pops - p0, 8);

        // Push and pop together at FIFO count 3.
        p0 = pops; base = 128'h6666_0000;
        res_ready = 1'b0;
        issue_cmd(1'b0, 1'b0, 5'b01000, 3'd7);
        send_beats(0, 4, 8, base, st);
        check("pp_stalls", st, 0);
        cyc();                       // FIFO reaches 3 with the 4th beat in stage 2
        res_ready = 1'b1;
        @(negedge clk);
        check("pp_res_valid", res_valid, 1);
        check("pp_op_ready_no_credit", op_ready, 0);
        cyc();
        @(negedge clk);
        check("pp_op_ready_after", op_ready, 1);
        cyc();
        send_beats(4, 8, 8, base, st);
        wait_idle();
        check("pp_pops", pops - p0, 8);

        // Reset with 2 results in flight and 2 queued.
        res_ready = 1'b0; base = 128'h7777_0000;
        issue_cmd(1'b0, 1'b0, 5'b01000, 3'd7);
        send_beats(0, 4, 8, base, st);
        rst = 1'b1;
        exp_q.delete();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        cyc();
        res_ready = 1'b1; p0 = pops; base = 128'h8888_0000;
        issue_cmd(1'b0, 1'b0, 5'b01000, 3'd1);
        send_beats(0, 2, 2, base, st);
        wait_idle();
        check("post_rst_pops", pops - p0, 2);

        // Commands are blocked while a command is in ISSUE or DRAIN.
        p0 = pops; base = 128'h9999_0000;
        g_hi = 1'b0; g_sg = 1'b0; g_osz = 5'b00001;
        issue_cmd(1'b0, 1'b0, 5'b00001, 3'd1);
        cmd_valid = 1'b1; cmd_is_high = 1'b1; cmd_is_signed = 1'b1; cmd_osize_vector = 5'b10000;
        @(negedge clk);
        check("blk_issue_cmd_ready", cmd_ready, 0);
        cyc();
        send_beats(0, 2, 2, base, st);
        @(negedge clk);
        check("blk_drain_cmd_ready", cmd_ready, 0);
        cyc();
        cmd_valid = 1'b0;
        wait_idle();
        check("blk_pops", pops - p0, 2);
        check("blk_no_new_cmd", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
